// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of the UART transmitter. A drain FSM kicks one byte at a time
// and polls the transmitter busy flag before handing over the next one.
module uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wen,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        tx_wen,
    output logic [31:0] tx_addr,
    output logic [31:0] tx_wdata,
    input  logic [31:0] tx_rdata
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LEVEL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [1:0] {IDLE, GUARD, POLL} state_t;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic                  overflow_q, overflow_d;
    logic [31:0]           div_q, div_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  tx_wen_q, tx_wen_d;
    logic [31:0]           tx_addr_q, tx_addr_d;
    logic [31:0]           tx_wdata_q, tx_wdata_d;
    state_t                state_q, state_d;
    logic [1:0]            guard_q, guard_d;

    logic [7:0] offset;
    logic       wr_push, wr_div, wr_stat, wr_flush;
    logic       full, busy, push, kick;
    logic [7:0] head;
    logic       unused_ok;

    assign offset   = addr[7:0];
    assign wr_push  = wen && (offset == 8'h00);
    assign wr_div   = wen && (offset == 8'h04);
    assign wr_stat  = wen && (offset == 8'h08);
    assign wr_flush = wen && (offset == 8'h0C);

    // Full uses the pre-pop level, so a push is dropped even when a pop happens alongside.
    assign full = (level_q == LEVEL_FULL);
    assign busy = (level_q != '0) || (state_q != IDLE);
    assign push = wr_push && !full;
    // A divider forward owns the tx port next cycle, so the kick waits one cycle.
    assign kick = (state_q == IDLE) && (level_q != '0) && !wr_div;
    assign head = mem[rd_ptr_q];

    assign unused_ok = ^{addr[31:8], tx_rdata[31:1]};

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        div_d      = div_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (kick) rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !kick) level_d = level_q + 1'b1;
        else if (kick && !push) level_d = level_q - 1'b1;
        if (wr_push && full) overflow_d = 1'b1;
        if (wr_stat) overflow_d = 1'b0;
        if (wr_div) div_d = wdata;
        if (wr_flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            overflow_d = 1'b0;
        end
    end

    always_comb begin
        tx_wen_d   = 1'b0;
        tx_addr_d  = 32'd8;
        tx_wdata_d = 32'd0;
        if (wr_div) begin
            tx_wen_d   = 1'b1;
            tx_addr_d  = 32'd4;
            tx_wdata_d = wdata;
        end else if (kick) begin
            tx_wen_d   = 1'b1;
            tx_addr_d  = 32'd0;
            tx_wdata_d = {24'd0, head};
        end
    end

    // Guard spans the kick cycle, the transmitter update and the registered busy readback.
    always_comb begin
        state_d = state_q;
        guard_d = guard_q;
        case (state_q)
            IDLE: begin
                if (kick) begin
                    state_d = GUARD;
                    guard_d = 2'd3;
                end
            end
            GUARD: begin
                if (guard_q == 2'd0) state_d = POLL;
                else guard_d = guard_q - 2'd1;
            end
            POLL: begin
                if (!tx_rdata[0]) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rdata_d = rdata_q;
        if (!wen) begin
            case (offset)
                8'h00:   rdata_d = 32'd0;
                8'h04:   rdata_d = div_q;
                8'h08:   rdata_d = {29'd0, overflow_q, full, busy};
                8'h0C:   rdata_d = {{(31-DEPTH_LOG2){1'b0}}, level_q};
                default: rdata_d = rdata_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= wdata[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            div_q      <= 32'd1;
            rdata_q    <= 32'd0;
            tx_wen_q   <= 1'b0;
            tx_addr_q  <= 32'd8;
            tx_wdata_q <= 32'd0;
            state_q    <= IDLE;
            guard_q    <= 2'd0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            div_q      <= div_d;
            rdata_q    <= rdata_d;
            tx_wen_q   <= tx_wen_d;
            tx_addr_q  <= tx_addr_d;
            tx_wdata_q <= tx_wdata_d;
            state_q    <= state_d;
            guard_q    <= guard_d;
        end
    end

    assign rdata    = rdata_q;
    assign tx_wen   = tx_wen_q;
    assign tx_addr  = tx_addr_q;
    assign tx_wdata = tx_wdata_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: behavioural transmitter model with serial decoder,
// directed scenarios with hand-computed expectations.
module tb_uart_tx_fifo;
    logic        clk;
    logic        reset;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        tx_wen;
    logic [31:0] tx_addr;
    logic [31:0] tx_wdata;
    logic [31:0] tx_rdata = 32'd0;

    int total = 0;
    int bad   = 0;

    uart_tx_fifo #(.DEPTH_LOG2(4)) dut (
        .clk(clk), .reset(reset), .wen(wen), .addr(addr), .wdata(wdata),
        .rdata(rdata), .tx_wen(tx_wen), .tx_addr(tx_addr), .tx_wdata(tx_wdata),
        .tx_rdata(tx_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transmitter model: start bit, 8 data bits LSB first, stop bit; each bit m_div cycles.
    logic [31:0] m_div   = 32'd1;
    logic        m_busy  = 1'b0;
    logic [9:0]  m_shift = 10'h3FF;
    int          m_bitcnt = 0;
    int          m_cyc    = 0;
    logic [7:0]  kick_log [64];
    int          kick_cnt = 0;
    int          kick_while_busy = 0;
    logic        txd;

    assign txd = m_busy ? m_shift[0] : 1'b1;

    always @(posedge clk) begin
        if (tx_wen === 1'b1 && tx_addr === 32'd4) m_div <= tx_wdata;
        if (tx_wen === 1'b1 && tx_addr === 32'd0) begin
            if (kick_cnt < 64) kick_log[kick_cnt] <= tx_wdata[7:0];
            kick_cnt <= kick_cnt + 1;
            if (m_busy) kick_while_busy <= kick_while_busy + 1;
            m_busy   <= 1'b1;
            m_shift  <= {1'b1, tx_wdata[7:0], 1'b0};
            m_bitcnt <= 0;
            m_cyc    <= 0;
        end else if (m_busy) begin
            if (m_cyc == int'(m_div) - 1) begin
                m_cyc    <= 0;
                m_shift  <= {1'b1, m_shift[9:1]};
                m_bitcnt <= m_bitcnt + 1;
                if (m_bitcnt == 9) m_busy <= 1'b0;
            end else begin
                m_cyc <= m_cyc + 1;
            end
        end
        if (tx_wen === 1'b0 && tx_addr === 32'd8) tx_rdata <= {31'd0, m_busy};
    end

    // Serial decoder samples each bit at its centre; a bad stop bit logs 0xFF.
    int         d_state = 0;
    int         d_cnt   = 0;
    int         d_bit   = 0;
    logic [7:0] d_sh    = 8'd0;
    logic [7:0] dec_log [64];
    int         dec_cnt = 0;

    always @(posedge clk) begin
        if (d_state == 0) begin
            if (txd == 1'b0) begin
                d_state <= 1;
                d_cnt   <= 2;
                d_bit   <= 1;
            end
        end else begin
            d_cnt <= d_cnt + 1;
            if (d_cnt == d_bit * int'(m_div) + int'(m_div) / 2) begin
                if (d_bit <= 8) begin
                    d_sh  <= {txd, d_sh[7:1]};
                    d_bit <= d_bit + 1;
                end else begin
                    d_state <= 0;
                    if (dec_cnt < 64) dec_log[dec_cnt] <= txd ? d_sh : 8'hFF;
                    dec_cnt <= dec_cnt + 1;
                end
            end
        end
    end

    task automatic cpu_drive(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        wen = 1'b1; addr = a; wdata = d;
    endtask

    task automatic cpu_idle();
        @(negedge clk);
        wen = 1'b0; addr = 32'h10; wdata = 32'd0;
    endtask

    task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
        cpu_drive(a, d);
        cpu_idle();
    endtask

    task automatic cpu_read(input logic [31:0] a, output logic [31:0] v);
        @(negedge clk);
        wen = 1'b0; addr = a;
        @(negedge clk);
        v = rdata; addr = 32'h10;
    endtask

    task automatic wait_drained(input int n_kicks, input int bound, output bit expired);
        expired = 1'b1;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (kick_cnt >= n_kicks && !m_busy && d_state == 0) begin
                expired = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] v;
        reset = 1'b1; wen = 1'b0; addr = 32'h10; wdata = 32'd0;
        repeat (2) @(negedge clk);
        total++; if (tx_wen !== 1'b0) begin bad++; $display("FAIL reset_tx_wen got=%0h want=0", tx_wen); end
        total++; if (tx_addr !== 32'd8) begin bad++; $display("FAIL reset_tx_addr got=%0h want=8", tx_addr); end
        total++; if (tx_wdata !== 32'd0) begin bad++; $display("FAIL reset_tx_wdata got=%0h want=0", tx_wdata); end
        total++; if (rdata !== 32'd0) begin bad++; $display("FAIL reset_rdata got=%0h want=0", rdata); end
        reset = 1'b0;
        cpu_read(32'h8, v);
        total++; if (v !== 32'd0) begin bad++; $display("FAIL reset_status got=%0h want=0", v); end
        cpu_read(32'hC, v);
        total++; if (v !== 32'd0) begin bad++; $display("FAIL reset_level got=%0h want=0", v); end
        cpu_read(32'h4, v);
        total++; if (v !== 32'd1) begin bad++; $display("FAIL reset_divider got=%0h want=1", v); end
        $display("test_reset done");
    endtask

    task automatic test_div_forward();
        logic [31:0] v;
        cpu_drive(32'h4, 32'h1B2);
        cpu_idle();
        total++; if (tx_wen !== 1'b1 || tx_addr !== 32'd4 || tx_wdata !== 32'h1B2) begin
            bad++; $display("FAIL div_fwd got wen=%0h addr=%0h data=%0h want 1/4/1b2", tx_wen, tx_addr, tx_wdata);
        end
        @(negedge clk);
        total++; if (tx_wen !== 1'b0 || tx_addr !== 32'd8) begin
            bad++; $display("FAIL div_fwd_release got wen=%0h addr=%0h want 0/8", tx_wen, tx_addr);
        end
        cpu_read(32'h4, v);
        total++; if (v !== 32'h1B2) begin bad++; $display("FAIL div_readback got=%0h want=1b2", v); end
        $display("test_div_forward done");
    endtask

    task automatic test_ordering();
        logic [31:0] v;
        logic [7:0]  exp_b [3];
        int          kb, db;
        bit          to;
        exp_b[0] = 8'h41; exp_b[1] = 8'h42; exp_b[2] = 8'h43;
        cpu_write(32'h4, 32'd4);
        kb = kick_cnt; db = dec_cnt;
        cpu_drive(32'h0, 32'h41);
        cpu_drive(32'h0, 32'h42);
        cpu_drive(32'h0, 32'h43);
        cpu_idle();
        cpu_read(32'h8, v);
        total++; if (v[0] !== 1'b1) begin bad++; $display("FAIL order_busy_during got=%0h want=1", v[0]); end
        wait_drained(kb + 3, 1000, to);
        total++; if (to !== 1'b0) begin bad++; $display("FAIL order_timeout got=expired want=drained"); end
        total++; if (kick_cnt - kb !== 3) begin bad++; $display("FAIL order_kicks got=%0d want=3", kick_cnt - kb); end
        for (int i = 0; i < 3; i++) begin
            total++; if (kick_log[kb + i] !== exp_b[i]) begin
                bad++; $display("FAIL order_kick%0d got=%0h want=%0h", i, kick_log[kb + i], exp_b[i]);
            end
            total++; if (dec_log[db + i] !== exp_b[i]) begin
                bad++; $display("FAIL order_line%0d got=%0h want=%0h", i, dec_log[db + i], exp_b[i]);
            end
        end
        repeat (6) @(negedge clk);
        cpu_read(32'h8, v);
        total++; if (v !== 32'd0) begin bad++; $display("FAIL order_busy_after got=%0h want=0", v); end
        $display("test_ordering done");
    endtask

    task automatic test_overflow();
        logic [31:0] v;
        int          kb, db;
        bit          to;
        cpu_write(32'h4, 32'd1000);
        kb = kick_cnt; db = dec_cnt;
        for (int i = 0; i < 16; i++) cpu_drive(32'h0, 32'h50 + i);
        cpu_idle();
        cpu_read(32'hC, v);
        total++; if (v !== 32'd15) begin bad++; $display("FAIL ovf_level15 got=%0d want=15", v); end
        cpu_read(32'h8, v);
        total++; if (v !== 32'd1) begin bad++; $display("FAIL ovf_status_notfull got=%0h want=1", v); end
        cpu_drive(32'h0, 32'h60);
        cpu_drive(32'h0, 32'h61);
        cpu_idle();
        cpu_read(32'h8, v);
        total++; if (v !== 32'd7) begin bad++; $display("FAIL ovf_status_full got=%0h want=7", v); end
        cpu_read(32'hC, v);
        total++; if (v !== 32'd16) begin bad++; $display("FAIL ovf_level16 got=%0d want=16", v); end
        cpu_write(32'h8, 32'h0);
        cpu_read(32'h8, v);
        total++; if (v !== 32'd3) begin bad++; $display("FAIL ovf_clear got=%0h want=3", v); end
        cpu_write(32'hC, 32'h0);
        cpu_read(32'hC, v);
        total++; if (v !== 32'd0) begin bad++; $display("FAIL ovf_flush_level got=%0d want=0", v); end
        cpu_read(32'h8, v);
        total++; if (v !== 32'd1) begin bad++; $display("FAIL ovf_flush_status got=%0h want=1", v); end
        wait_drained(kb + 1, 12000, to);
        total++; if (to !== 1'b0) begin bad++; $display("FAIL ovf_timeout got=expired want=drained"); end
        repeat (30) @(negedge clk);
        total++; if (kick_cnt - kb !== 1) begin bad++; $display("FAIL ovf_kicks got=%0d want=1", kick_cnt - kb); end
        total++; if (dec_log[db] !== 8'h50) begin bad++; $display("FAIL ovf_line got=%0h want=50", dec_log[db]); end
        cpu_read(32'h8, v);
        total++; if (v !== 32'd0) begin bad++; $display("FAIL ovf_idle_status got=%0h want=0", v); end
        cpu_write(32'h4, 32'd4);
        cpu_read(32'h4, v);
        total++; if (v !== 32'd4) begin bad++; $display("FAIL ovf_div_restore got=%0d want=4", v); end
        $display("test_overflow done");
    endtask

    task automatic test_div_vs_kick();
        int kb, db;
        bit to;
        kb = kick_cnt; db = dec_cnt;
        cpu_drive(32'h0, 32'h5A);
        cpu_drive(32'h4, 32'd4);
        cpu_idle();
        total++; if (tx_wen !== 1'b1 || tx_addr !== 32'd4 || tx_wdata !== 32'd4) begin
            bad++; $display("FAIL dvk_forward got wen=%0h addr=%0h data=%0h want 1/4/4", tx_wen, tx_addr, tx_wdata);
        end
        @(negedge clk);
        total++; if (tx_wen !== 1'b1 || tx_addr !== 32'd0 || tx_wdata !== 32'h5A) begin
            bad++; $display("FAIL dvk_kick got wen=%0h addr=%0h data=%0h want 1/0/5a", tx_wen, tx_addr, tx_wdata);
        end
        wait_drained(kb + 1, 1000, to);
        total++; if (to !== 1'b0) begin bad++; $display("FAIL dvk_timeout got=expired want=drained"); end
        total++; if (dec_log[db] !== 8'h5A) begin bad++; $display("FAIL dvk_line got=%0h want=5a", dec_log[db]); end
        repeat (10) @(negedge clk);
        $display("test_div_vs_kick done");
    endtask

    task automatic test_flush_guard();
        logic [31:0] v;
        int          kb, db;
        bit          to;
        kb = kick_cnt; db = dec_cnt;
        cpu_drive(32'h0, 32'h61);
        cpu_drive(32'h0, 32'h62);
        cpu_drive(32'hC, 32'h0);
        cpu_idle();
        cpu_read(32'hC, v);
        total++; if (v !== 32'd0) begin bad++; $display("FAIL fg_level got=%0d want=0", v); end
        cpu_read(32'h8, v);
        total++; if (v !== 32'd1) begin bad++; $display("FAIL fg_status got=%0h want=1", v); end
        wait_drained(kb + 1, 1000, to);
        total++; if (to !== 1'b0) begin bad++; $display("FAIL fg_timeout got=expired want=drained"); end
        repeat (30) @(negedge clk);
        total++; if (kick_cnt - kb !== 1) begin bad++; $display("FAIL fg_kicks got=%0d want=1", kick_cnt - kb); end
        total++; if (dec_cnt - db !== 1 || dec_log[db] !== 8'h61) begin
            bad++; $display("FAIL fg_line got=%0h count=%0d want=61 count=1", dec_log[db], dec_cnt - db);
        end
        $display("test_flush_guard done");
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        int          kb, db;
        bit          to;
        kb = kick_cnt; db = dec_cnt;
        for (int i = 0; i < 6; i++) cpu_drive(32'h0, 32'h71 + i);
        cpu_idle();
        repeat (8) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wait_drained(kb + 1, 1000, to);
        total++; if (to !== 1'b0) begin bad++; $display("FAIL rm_timeout got=expired want=drained"); end
        repeat (30) @(negedge clk);
        total++; if (kick_cnt - kb !== 1) begin bad++; $display("FAIL rm_kicks got=%0d want=1", kick_cnt - kb); end
        total++; if (dec_cnt - db !== 1 || dec_log[db] !== 8'h71) begin
            bad++; $display("FAIL rm_line got=%0h count=%0d want=71 count=1", dec_log[db], dec_cnt - db);
        end
        cpu_read(32'hC, v);
        total++; if (v !== 32'd0) begin bad++; $display("FAIL rm_level got=%0d want=0", v); end
        cpu_read(32'h4, v);
        total++; if (v !== 32'd1) begin bad++; $display("FAIL rm_divider got=%0d want=1", v); end
        $display("test_reset_mid done");
    endtask

    task automatic test_no_kick_busy();
        total++; if (kick_while_busy !== 0) begin
            bad++; $display("FAIL kick_while_busy got=%0d want=0", kick_while_busy);
        end
    endtask

    initial begin
        test_reset();
        test_div_forward();
        test_ordering();
        test_overflow();
        test_div_vs_kick();
        test_flush_guard();
        test_reset_mid();
        test_no_kick_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
